if_id_skid_reg: RTL and testbench
=================================

// Module: if_id_skid_reg
// PURPOSE
//   IF->ID pipeline stage register of the RISC-V core, built around a two-entry skid buffer.
//   Accepts {pc, instr} from fetch under valid/ready and presents it to decode.
//   Holds full throughput (one transfer per cycle) while keeping in_ready fully
//   registered, which breaks the decode-stall -> fetch combinational path.
//   Flush drops everything in flight (branch/jump redirect).
// PARAMETERS
//   XLEN      32             width of pc
//   RESET_PC  32'h0000_0000  value driven on out_pc while out_valid=0
//   NOP_INSTR 32'h0000_0013  addi x0,x0,0; driven on out_instr while out_valid=0
// PORTS
//   clk        in   1     clock, rising-edge
//   rst        in   1     asynchronous, active-low reset
//   flush      in   1     sync; discard all held entries and any same-cycle input
//   in_valid   in   1     fetch offers {in_pc,in_instr}
//   in_ready   out  1     registered; stage can accept this cycle
//   in_pc      in   XLEN  pc of offered instruction
//   in_instr   in   32    offered instruction word
//   out_valid  out  1     decode is offered {out_pc,out_instr}
//   out_ready  in   1     decode accepts this cycle
//   out_pc     out  XLEN  pc of head entry (RESET_PC when empty)
//   out_instr  out  32    head instruction (NOP_INSTR when empty)
//   occupancy  out  2     entries held: 0, 1 or 2
// BEHAVIOUR
//   - accept = in_valid & in_ready; consume = out_valid & out_ready.
//   - Storage: main {pc,instr} (drives outputs) and skid {pc,instr}.
//   - State machine: EMPTY(occ 0), ONE(occ 1), FULL(occ 2). Encoding is free.
//     out_valid = (state != EMPTY); in_ready = (state != FULL), both from flops.
//   - Transitions (no flush):
//       EMPTY: accept -> ONE, main<=in; else stay.
//       ONE:   accept&consume -> ONE, main<=in;  accept&!consume -> FULL, skid<=in;
//              !accept&consume -> EMPTY;           neither -> hold.
//       FULL:  in_ready=0, so no accept; consume -> ONE, main<=skid; else hold.
//   - Ordering is strict FIFO; skid is never presented before main.
//   - Latency: in -> out is 1 cycle when EMPTY. Steady-state throughput is 1/cycle.
//     One stall cycle from decode (out_ready=0) lands the in-flight word in skid.
//   - flush: highest priority. Next state is EMPTY, in_ready=1, out_valid=0,
//     and occupancy=0 at the next edge. A same-cycle accept is dropped, and so is
//     a same-cycle consume (decode must ignore it).
//   - A consume is legal while flush is high but has no effect on the final state.
//   - While in EMPTY, data flops hold their old contents, but the outputs are muxed
//     to RESET_PC / NOP_INSTR. No X may reach out_pc or out_instr.
//   - Inputs are don't-care while in_valid=0. out_* must not change while
//     out_valid=1 & out_ready=0 (stable-until-accepted).
//   - Reset (rst=0, async): state=EMPTY, out_valid=0, in_ready=1, occupancy=0,
//     out_pc=RESET_PC, out_instr=NOP_INSTR, data flops cleared to 0.
//     Reset mid-stream discards all entries immediately, without waiting for clk.
//   - Release of rst is synchronous to clk upstream. No accept occurs on the
//     release edge unless in_valid is high and rst is already 1 before that edge.
// TESTING
//   1 Reset: hold rst=0 with clk running -> out_valid=0, in_ready=1, occ=0,
//     out_instr=32'h13, out_pc=0.
//   2 Streaming: out_ready=1, send pc 0x0,0x4,0x8,0xC back-to-back -> same order
//     on out with 1-cycle latency, in_ready stays 1, occ stays 1.
//   3 Skid: stream pc 0x100,0x104,0x108 with out_ready=0 from cycle 2 ->
//     occ=2, in_ready=0, out_pc held 0x100. Raise out_ready ->
//     0x100,0x104,0x108 emerge in order, none lost or duplicated.
//   4 Flush while FULL, with in_valid=1 pc=0x200 in the same cycle -> next cycle
//     occ=0, out_valid=0, out_instr=32'h13. 0x200 is never output; the next offer
//     pc=0x300 is output 1 cycle later.
//   5 Async reset mid-stream: assert rst=0 between clk edges while occ=2 ->
//     out_valid falls before the next edge. After release, the first offer
//     pc=0x40 is output first.
//   6 Random valid/ready (10k cycles) vs a scoreboard queue -> exact order match,
//     no loss or duplication, occupancy never exceeds 2.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline stage register built around a two-entry skid buffer.
// Passes {pc, instr} from fetch to decode at one transfer per cycle. in_ready
// comes straight from a flop, so a decode stall never reaches fetch
// combinationally. Flush drops everything in flight on a redirect.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous; discard held entries and any same-cycle input
//   in_valid   fetch offers {in_pc, in_instr}
//   in_ready   registered; stage can accept this cycle
//   in_pc      pc of offered instruction
//   in_instr   offered instruction word
//   out_valid  registered; decode is offered {out_pc, out_instr}
//   out_ready  decode accepts this cycle
//   out_pc     pc of head entry, RESET_PC when empty
//   out_instr  head instruction, NOP_INSTR when empty
//   occupancy  registered count of held entries (0..2)
module if_id_skid_reg #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      RESET_PC  = '0,
    parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [1:0]      occupancy
);

    localparam int unsigned ILEN  = 32;
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [OCC_W-1:0]   occ_nx;

    logic [XLEN-1:0]    main_pc;
    logic [ILEN-1:0]    main_instr;
    logic [XLEN-1:0]    skid_pc;
    logic [ILEN-1:0]    skid_instr;

    logic               accept;
    logic               consume;
    logic               load_main;
    logic               main_from_skid;
    logic               load_skid;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // Next state and data-path load enables; flush overrides everything.
    always_comb begin
        state_nx       = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nx  = ST_ONE;
                        load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_nx  = ST_FULL;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_nx = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a consume can move us.
                    if (consume) begin
                        state_nx       = ST_ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_EMPTY;
                end
            endcase
        end
    end

    // Entry count implied by the next state.
    always_comb begin
        occ_nx = OCC_W'(0);
        case (state_nx)
            ST_ONE:  occ_nx = OCC_W'(1);
            ST_FULL: occ_nx = OCC_W'(2);
            default: occ_nx = OCC_W'(0);
        endcase
    end

    // State and handshake flops; handshakes are precomputed from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= OCC_W'(0);
        end else begin
            state     <= state_nx;
            out_valid <= (state_nx != ST_EMPTY);
            in_ready  <= (state_nx != ST_FULL);
            occupancy <= occ_nx;
        end
    end

    // Main and skid storage; contents go stale (not cleared) when emptied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_pc    <= '0;
            main_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            if (load_main) begin
                main_pc    <= main_from_skid ? skid_pc    : in_pc;
                main_instr <= main_from_skid ? skid_instr : in_instr;
            end
            if (load_skid) begin
                skid_pc    <= in_pc;
                skid_instr <= in_instr;
            end
        end
    end

    // Mask stale storage so decode sees a clean NOP at RESET_PC when empty.
    assign out_pc    = out_valid ? main_pc    : RESET_PC;
    assign out_instr = out_valid ? main_instr : NOP_INSTR;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: directed scenarios plus a random
// valid/ready/flush soak, checked against a FIFO model of at most two entries.
module tb_if_id_skid_reg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  occupancy;

    int   n_cmp  = 0;
    int   n_fail = 0;
    ent_t exp_q[$];

    if_id_skid_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle compare against the model head, then advance the
    // model by what the coming rising edge will do.
    always @(negedge clk) begin
        bit will_acc;
        if (!rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready",  32'(in_ready),  32'd1);
            chk("rst_occupancy", 32'(occupancy), 32'd0);
            chk("rst_out_pc",    out_pc,         RESET_PC);
            chk("rst_out_instr", out_instr,      NOP_INSTR);
            exp_q.delete();
        end else begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
            chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
            if (exp_q.size() != 0) begin
                chk("out_pc",    out_pc,    exp_q[0].pc);
                chk("out_instr", out_instr, exp_q[0].instr);
            end else begin
                chk("idle_pc",    out_pc,    RESET_PC);
                chk("idle_instr", out_instr, NOP_INSTR);
            end
            will_acc = in_valid && (exp_q.size() < 2);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
                if (will_acc) exp_q.push_back('{pc: in_pc, instr: in_instr});
            end
        end
    end

    // Present one cycle of inputs, then advance to just after the next edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = {pc[15:0], 16'hC0DE} ^ 32'h0000_0013;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_out_valid", 32'(out_valid), 32'd0);
        chk("t1_out_instr", out_instr, 32'h13);
        chk("t1_out_pc",    out_pc,    32'h0);
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming at full rate.
        step(1'b1, 32'h0, 1'b1, 1'b0);
        chk("t2_first_pc", out_pc, 32'h0);
        step(1'b1, 32'h4, 1'b1, 1'b0);
        step(1'b1, 32'h8, 1'b1, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        chk("t2_last_pc", out_pc, 32'hC);
        chk("t2_occ",     32'(occupancy), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Decode stall lands the in-flight word in the skid entry.
        step(1'b1, 32'h100, 1'b1, 1'b0);
        step(1'b1, 32'h104, 1'b0, 1'b0);
        step(1'b1, 32'h108, 1'b0, 1'b0);
        chk("t3_occ",      32'(occupancy), 32'd2);
        chk("t3_in_ready", 32'(in_ready),  32'd0);
        chk("t3_out_pc",   out_pc,         32'h100);
        step(1'b1, 32'h108, 1'b1, 1'b0);
        chk("t3_next_pc", out_pc, 32'h104);
        step(1'b1, 32'h108, 1'b1, 1'b0);
        chk("t3_last_pc", out_pc, 32'h108);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while FULL drops held entries and the same-cycle offer.
        step(1'b1, 32'h180, 1'b0, 1'b0);
        step(1'b1, 32'h184, 1'b0, 1'b0);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        chk("t4_occ",       32'(occupancy), 32'd0);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_out_instr", out_instr,      32'h13);
        step(1'b1, 32'h300, 1'b0, 1'b0);
        chk("t4_out_pc", out_pc, 32'h300);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges while FULL.
        step(1'b1, 32'h20, 1'b0, 1'b0);
        step(1'b1, 32'h24, 1'b0, 1'b0);
        chk("t5_pre_occ", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_occ",   32'(occupancy), 32'd0);
        chk("t5_async_pc",    out_pc,         RESET_PC);
        @(posedge clk);
        #1;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b1, 32'h40, 1'b1, 1'b0);
        chk("t5_first_pc", out_pc, 32'h40);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Random valid/ready/flush soak.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 $urandom() & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 39) == 0));
        end

        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(out_valid),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
